// File: rtl/nphase_pkg.sv
`default_nettype none
// ============================================================================
// nphase_pkg : shared FSM state type and zero-clamp helper for the
//              N-phase non-overlapping clock generator.
// Rev 1.0
// ============================================================================
package nphase_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    // Intervals of zero length are promoted to one cycle.
    function automatic logic [31:0] max1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonoverlap_timer.sv
`default_nettype none
// ============================================================================
// nonoverlap_timer : loadable down-counter timing the high and dead intervals.
// Rev 1.0
// ============================================================================
module nonoverlap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_value = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/nphase_nonoverlap_gen.sv
`default_nettype none
// ============================================================================
// nphase_nonoverlap_gen : counter-based N-phase non-overlapping clock generator
//                         with programmable high/dead time and graceful stop.
// Rev 1.0
// ============================================================================
module nphase_nonoverlap_gen
    import nphase_pkg::*;
#(
    parameter int N_PHASES = 2,
    parameter int HW       = 8,
    parameter int DW       = 4,
    parameter int PW       = $clog2(N_PHASES)
) (
    input  logic                CLK_IN,
    input  logic                RST,
    input  logic                EN,
    input  logic [HW-1:0]       HIGH_CYC,
    input  logic [DW-1:0]       DEAD_CYC,
    output logic [N_PHASES-1:0] PHI_OUT,
    output logic [N_PHASES-1:0] PHI_OUT_N,
    output logic [PW-1:0]       PHASE_IDX,
    output logic                CYCLE_DONE,
    output logic                BUSY
);

    localparam int TW = (HW > DW) ? HW : DW;
    localparam logic [N_PHASES-1:0] c_phi0 = {{(N_PHASES-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]       c_last = PW'(N_PHASES - 1);

    state_t              r_state, w_state_nxt;
    logic [N_PHASES-1:0] r_phi, r_phi_n, w_phi_nxt;
    logic [PW-1:0]       r_idx, w_idx_nxt;
    logic                r_done, w_done_nxt;
    logic [HW-1:0]       r_high, w_high_nxt, w_high_in;
    logic [DW-1:0]       r_dead, w_dead_nxt, w_dead_in;
    logic                w_start;
    logic                w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [TW-1:0]       w_tmr_val, w_tmr_value;

    assign w_high_in = HW'(max1(32'(HIGH_CYC)));
    assign w_dead_in = DW'(max1(32'(DEAD_CYC)));

    nonoverlap_timer #(
        .W (TW)
    ) u_timer (
        .clk        (CLK_IN),
        .rst        (RST),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_value    (w_tmr_value),
        .o_zero     (w_tmr_zero)
    );

    // Timer saturates at zero; a load on the same edge takes priority.
    assign w_tmr_dec = (r_state != ST_IDLE) && (w_tmr_value != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_phi_nxt   = r_phi;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_high_nxt  = r_high;
        w_dead_nxt  = r_dead;
        w_start     = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;

        case (r_state)
            ST_IDLE: begin
                w_start = EN;
            end
            ST_ACTIVE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_DEAD;
                    w_phi_nxt   = '0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(r_dead) - TW'(1);
                end
            end
            ST_DEAD: begin
                if (w_tmr_zero) begin
                    if (r_idx == c_last) begin
                        w_done_nxt  = 1'b1;
                        w_start     = EN;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                        w_idx_nxt   = r_idx + PW'(1);
                        w_phi_nxt   = c_phi0 << w_idx_nxt;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(r_high) - TW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phi_nxt   = '0;
            end
        endcase

        // Cycle start: configuration is captured only here.
        if (w_start) begin
            w_state_nxt = ST_ACTIVE;
            w_idx_nxt   = '0;
            w_phi_nxt   = c_phi0;
            w_high_nxt  = w_high_in;
            w_dead_nxt  = w_dead_in;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(w_high_in) - TW'(1);
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_phi   <= '0;
            r_phi_n <= '1;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_high  <= '0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phi   <= w_phi_nxt;
            r_phi_n <= ~w_phi_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_high  <= w_high_nxt;
            r_dead  <= w_dead_nxt;
        end
    end

    assign PHI_OUT    = r_phi;
    assign PHI_OUT_N  = r_phi_n;
    assign PHASE_IDX  = r_idx;
    assign CYCLE_DONE = r_done;
    assign BUSY       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
